// File: rtl/candy_dispenser_param.sv
// candy_dispenser_param
// Parametrised coin-operated candy dispenser controller.
//   - Accepts nickel / dime / quarter sensor levels and credits one coin per
//     rising edge, in 5-cent units.
//   - Vends at PRICE, returns any remainder one nickel pulse per cycle.
//   - Tracks stock, with refill to STOCK_INIT from IDLE.
// Build option:
//   CANDY_REFUND_EN : when defined, cancel in IDLE refunds the held credit
//                     through the change hopper. When undefined, cancel is
//                     ignored and credit persists until a vend.
module candy_dispenser_param #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 6,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                five,
    input  logic                ten,
    input  logic                twentyfive,
    input  logic                cancel,
    input  logic                refill,
    output logic                candy,
    output logic                change,
    output logic                coin_reject,
    output logic                sold_out,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    // Constants sized to the registers they are compared against
    localparam logic [CREDIT_W:0]   MAX_EXT    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   PRICE_EXT  = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);
    localparam logic [STOCK_W-1:0]  STOCK_LOAD = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_ONE  = STOCK_W'(1);

    // Value of the coins that produced an edge this cycle, in nickels.
    // Simultaneous coins are summed; the maximum is 8, so 4 bits suffice.
    function automatic logic [3:0] coin_value(
        input logic n_edge,
        input logic d_edge,
        input logic q_edge
    );
        logic [3:0] v;
        v = 4'd0;
        if (n_edge) v = v + 4'd1;
        if (d_edge) v = v + 4'd2;
        if (q_edge) v = v + 4'd5;
        return v;
    endfunction

    // Credit plus deposit, one bit wider than credit so it cannot wrap
    // before the ceiling compare.
    function automatic logic [CREDIT_W:0] credit_sum(
        input logic [CREDIT_W-1:0] cur,
        input logic [3:0]          add
    );
        return {1'b0, cur} + (CREDIT_W+1)'(add);
    endfunction

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [STOCK_W-1:0]  stock;
    logic [STOCK_W-1:0]  stock_nxt;
    logic                reject_nxt;

    // Previous sensor levels for edge detection
    logic five_p0;
    logic ten_p0;
    logic twentyfive_p0;

    logic                five_edge;
    logic                ten_edge;
    logic                twentyfive_edge;
    logic                coin_any;
    logic [3:0]          add;
    logic [CREDIT_W:0]   sum;
    logic                cancel_req;

    assign five_edge       = five       & ~five_p0;
    assign ten_edge        = ten        & ~ten_p0;
    assign twentyfive_edge = twentyfive & ~twentyfive_p0;
    assign coin_any        = five_edge | ten_edge | twentyfive_edge;
    assign add             = coin_value(five_edge, ten_edge, twentyfive_edge);
    assign sum             = credit_sum(credit, add);

`ifdef CANDY_REFUND_EN
    // A refund only makes sense when there is credit to return
    assign cancel_req = cancel & (credit != '0);
`else
    // Refund disabled: cancel has no effect on the machine
    assign cancel_req = cancel & 1'b0;
`endif

    // Sensor history: a coin counts only on the cycle its level rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            five_p0       <= 1'b0;
            ten_p0        <= 1'b0;
            twentyfive_p0 <= 1'b0;
        end else begin
            five_p0       <= five;
            ten_p0        <= ten;
            twentyfive_p0 <= twentyfive;
        end
    end

    // Next-state, credit, stock and reject decisions
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        stock_nxt  = stock;
        reject_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                // Refill does not block coin handling in the same cycle
                if (refill) begin
                    stock_nxt = STOCK_LOAD;
                end
                if (cancel_req) begin
                    state_nxt  = S_CHANGE;
                    reject_nxt = coin_any;
                end else if (sold_out || (sum > MAX_EXT)) begin
                    reject_nxt = coin_any;
                end else begin
                    credit_nxt = sum[CREDIT_W-1:0];
                    if (sum >= PRICE_EXT) begin
                        state_nxt = S_VEND;
                    end
                end
            end
            S_VEND: begin
                // Entry into VEND guarantees credit >= PRICE and stock > 0
                reject_nxt = coin_any;
                credit_nxt = credit - PRICE_C;
                stock_nxt  = stock - STOCK_ONE;
                state_nxt  = (credit > PRICE_C) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                // One nickel per cycle; leave on the edge credit hits zero
                reject_nxt = coin_any;
                if (credit != '0) begin
                    credit_nxt = credit - CREDIT_ONE;
                end
                if (credit <= CREDIT_ONE) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state, credit and stock registers; reset aborts any vend/refund
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            credit   <= '0;
            stock    <= STOCK_LOAD;
            sold_out <= (STOCK_LOAD == '0);
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            stock    <= stock_nxt;
            sold_out <= (stock_nxt == '0);
        end
    end

    // Reject strobe appears in the cycle after the edge that refused coins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= reject_nxt;
        end
    end

    // Moore decode of the actuator strobes
    assign candy  = (state == S_VEND);
    assign change = (state == S_CHANGE);
    assign busy   = candy | change;

endmodule

// File: tb/tb_candy_dispenser_param.sv
// Directed bench for candy_dispenser_param (PRICE 5, MAX_CREDIT 8,
// STOCK_INIT 1). Expected strobes are queued by the stimulus thread and
// consumed by a monitor that samples on the falling clock edge.
module tb_candy_dispenser_param;

    localparam int CW = 6;
    localparam logic [1:0] EV_CANDY  = 2'd0;
    localparam logic [1:0] EV_CHANGE = 2'd1;
    localparam logic [1:0] EV_REJECT = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [CW-1:0] cr;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          five = 1'b0;
    logic          ten = 1'b0;
    logic          twentyfive = 1'b0;
    logic          cancel = 1'b0;
    logic          refill = 1'b0;
    logic          candy;
    logic          change;
    logic          coin_reject;
    logic          sold_out;
    logic          busy;
    logic [CW-1:0] credit;

    int  vectors = 0;
    int  miscompares = 0;
    ev_t expq[$];

    candy_dispenser_param #(
        .PRICE(5), .MAX_CREDIT(8), .CREDIT_W(CW), .STOCK_W(4), .STOCK_INIT(1)
    ) dut (
        .clk(clk), .rst(rst), .five(five), .ten(ten), .twentyfive(twentyfive),
        .cancel(cancel), .refill(refill), .candy(candy), .change(change),
        .coin_reject(coin_reject), .sold_out(sold_out), .busy(busy),
        .credit(credit)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input int cr);
        ev_t e;
        e.kind = kind;
        e.cr   = CW'(cr);
        expq.push_back(e);
    endtask

    task automatic check_evt(input logic [1:0] kind);
        ev_t e;
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got kind=%0d credit=%0d at %0t, expected none",
                     kind, credit, $time);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.cr != credit ||
                (kind != EV_REJECT && busy != 1'b1)) begin
                miscompares++;
                $display("FAIL strobe: got kind=%0d credit=%0d busy=%0d at %0t, expected kind=%0d credit=%0d",
                         kind, credit, busy, $time, e.kind, e.cr);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                if (candy)       check_evt(EV_CANDY);
                if (change)      check_evt(EV_CHANGE);
                if (coin_reject) check_evt(EV_REJECT);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One-cycle pulse on the chosen sensors, followed by one low cycle
    task automatic coin(input logic f, input logic t, input logic q);
        five = f; ten = t; twentyfive = q;
        tick(1);
        five = 1'b0; ten = 1'b0; twentyfive = 1'b0;
        tick(1);
    endtask

    task automatic do_refill();
        refill = 1'b1;
        tick(1);
        refill = 1'b0;
        tick(1);
    endtask

    task automatic check_idle(input string nm, input int cr, input int so);
        chk({nm, "_credit"}, int'(credit), cr);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_sold_out"}, int'(sold_out), so);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state
        tick(1);
        chk("rst_candy", int'(candy), 0);
        chk("rst_change", int'(change), 0);
        chk("rst_reject", int'(coin_reject), 0);
        check_idle("rst", 0, 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // Quarter held four cycles: one vend, no change
        push(EV_CANDY, 5);
        twentyfive = 1'b1;
        tick(4);
        twentyfive = 1'b0;
        tick(3);
        check_idle("hold_q", 0, 1);
        do_refill();
        chk("refill1_sold_out", int'(sold_out), 0);

        // All three coins at once: credit 8, vend, three nickels back
        push(EV_CANDY, 8);
        push(EV_CHANGE, 3);
        push(EV_CHANGE, 2);
        push(EV_CHANGE, 1);
        coin(1'b1, 1'b1, 1'b1);
        tick(5);
        check_idle("all3", 0, 1);
        do_refill();

        // Two dimes: credit 4, no vend
        coin(1'b0, 1'b1, 1'b0);
        coin(1'b0, 1'b1, 1'b0);
        tick(1);
        check_idle("two_dimes", 4, 0);

        // Cancel with credit held
`ifdef CANDY_REFUND_EN
        push(EV_CHANGE, 4);
        push(EV_CHANGE, 3);
        push(EV_CHANGE, 2);
        push(EV_CHANGE, 1);
`endif
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
        tick(6);
`ifdef CANDY_REFUND_EN
        check_idle("cancel", 0, 0);
        coin(1'b0, 1'b1, 1'b0);
        coin(1'b0, 1'b1, 1'b0);
        tick(1);
        chk("redeposit_credit", int'(credit), 4);
`else
        check_idle("cancel_ignored", 4, 0);
`endif

        // Quarter on credit 4 would exceed the ceiling of 8
        push(EV_REJECT, 4);
        coin(1'b0, 1'b0, 1'b1);
        tick(2);
        check_idle("overflow", 4, 0);

        // A dime now reaches 6: vend with one nickel back
        push(EV_CANDY, 6);
        push(EV_CHANGE, 1);
        coin(1'b0, 1'b1, 1'b0);
        tick(4);
        check_idle("dime_to_6", 0, 1);
        do_refill();

        // Nickel arriving during change is refused
        push(EV_CANDY, 8);
        push(EV_CHANGE, 3);
        push(EV_CHANGE, 2);
        push(EV_REJECT, 2);
        push(EV_CHANGE, 1);
        coin(1'b1, 1'b1, 1'b1);
        five = 1'b1;
        tick(1);
        five = 1'b0;
        tick(5);
        check_idle("coin_in_change", 0, 1);

        // Sold out: quarter refused until refill
        push(EV_REJECT, 0);
        coin(1'b0, 1'b0, 1'b1);
        tick(2);
        check_idle("sold_out_reject", 0, 1);
        do_refill();
        chk("refill2_sold_out", int'(sold_out), 0);
        push(EV_CANDY, 5);
        coin(1'b0, 1'b0, 1'b1);
        tick(3);
        check_idle("after_refill_vend", 0, 1);
        do_refill();

        // Reset asserted in the middle of change return
        push(EV_CANDY, 8);
        push(EV_CHANGE, 3);
        coin(1'b1, 1'b1, 1'b1);
        #5;
        rst = 1'b0;
        #1;
        chk("midrst_change", int'(change), 0);
        chk("midrst_candy", int'(candy), 0);
        check_idle("midrst", 0, 0);
        tick(1);
        rst = 1'b1;
        tick(3);
        check_idle("post_rst", 0, 0);
        chk("post_rst_change", int'(change), 0);

        tick(2);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
